mmio_uart_port: RTL and testbench
=================================

MMIO_UART_PORT -- requirements
Module: mmio_uart_port

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (115200 baud at 50 MHz); legal range 8..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, RX FIFO entries; power of two, 2..16.
REQ-003 clock  input  1  single clock; all state on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low; 0 resets the block.
REQ-005 selected  input  1  qualifies read and write; when low, both are ignored.
REQ-006 rx_signal  input  1  asynchronous serial receive line, idle high.
REQ-007 tx_signal  output  1  serial transmit line, idle high.
REQ-008 address  input  8  byte address of register; only [3:2] decoded.
REQ-009 in_data  input  8  write data.
REQ-010 write  input  1  one-cycle register write strobe.
REQ-011 read  input  1  one-cycle register read strobe.
REQ-012 out_data  output  32  read data, combinational from address; zero-extended.

Function
REQ-013 Register map: 0x00 TXDATA (write), 0x04 RXDATA (read), 0x08 STATUS (read; write-1-to-clear); 0x0C reads 0, writes ignored.
REQ-014 STATUS bits: [0] rx_empty, [1] rx_full, [2] tx_busy, [3] rx_overrun (sticky), [4] rx_frame_err (sticky); [31:5] = 0.
REQ-015 out_data for 0x04 = head FIFO byte, or 0 if empty; valid same cycle as read, no wait states.
REQ-016 Read of 0x04 with selected=1 and FIFO non-empty pops one entry at the clock edge; read when empty: no pop, no flag change.
REQ-017 Reads of 0x00, 0x08, 0x0C have no side effects.
REQ-018 Write of 0x00 when tx_busy=0 loads in_data, sets tx_busy next cycle; when tx_busy=1 the write is dropped silently.
REQ-019 TX FSM states IDLE, START, DATA, STOP; each non-IDLE bit held exactly CLKS_PER_BIT cycles.
REQ-020 TX: START drives 0, DATA drives bits LSB first (8 bits), STOP drives 1, then IDLE; frame = 10*CLKS_PER_BIT cycles.
REQ-021 tx_signal SHALL change no later than one cycle after the accepting write edge; tx_busy clears at end of STOP.
REQ-022 rx_signal SHALL pass a 2-flop synchronizer before use.
REQ-023 RX FSM states IDLE, START, DATA, STOP; IDLE->START on synchronized falling level (0).
REQ-024 RX: START samples at CLKS_PER_BIT/2; if line high, return to IDLE (glitch reject); else sample each data bit and stop bit at full CLKS_PER_BIT intervals.
REQ-025 RX stop bit 1: push byte; stop bit 0: discard byte, set rx_frame_err; both return to IDLE after the stop sample.
REQ-026 Push when full and no simultaneous pop: byte dropped, rx_overrun set, FIFO unchanged.
REQ-027 Push and pop same cycle: both occur (full stays full, no overrun; empty-with-push is not a pop).
REQ-028 FIFO pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
REQ-029 STATUS write: in_data[3]=1 clears rx_overrun, in_data[4]=1 clears rx_frame_err; a set event same cycle wins over clear.
REQ-030 Write strobe with read strobe same cycle: both honoured per their addresses.

Reset
REQ-031 While reset=0: tx_signal=1, tx_busy=0, both FSMs IDLE, FIFO empty (rx_empty=1, rx_full=0), sticky flags 0, synchronizer flops 1.
REQ-032 Reset asserted mid-frame SHALL abort immediately; tx_signal=1 asynchronously; partial RX byte discarded.
REQ-033 First frame after reset release SHALL begin only on a fresh start bit.

Verification
REQ-034 Write 0x00=0xA5, CLKS_PER_BIT=8 -> tx_signal 0,1,0,1,0,0,1,0,1,1 each 8 cycles; tx_busy high 80 cycles.
REQ-035 Drive RX frame 0x3C -> STATUS=0x00 after stop sample; read 0x04 returns 0x0000003C; then STATUS=0x01.
REQ-036 Drive 5 frames (0x01..0x05), no reads -> rx_full=1, rx_overrun=1; reads return 0x01..0x04; STATUS write 0x08 clears overrun.
REQ-037 Frame 0x55 with stop bit 0 -> FIFO stays empty, STATUS=0x11; write 0x10 -> STATUS=0x01.
REQ-038 Low pulse of CLKS_PER_BIT/4 on rx_signal -> no push, STATUS unchanged (0x01).
REQ-039 Assert reset mid-TX-DATA -> tx_signal=1 within the reset cycle, STATUS=0x01 after release; second TXDATA write while busy -> transmitted byte unchanged.

Source files
------------

// File: rtl/mmio_uart_port.sv
// Memory-mapped UART: one-byte transmit holding register, RX FIFO, and a
// status register with sticky overrun / framing-error flags.
module mmio_uart_port #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        selected,
  input  logic        rx_signal,
  output logic        tx_signal,
  input  logic [7:0]  address,
  input  logic [7:0]  in_data,
  input  logic        write,
  input  logic        read,
  output logic [31:0] out_data
);

  localparam int CNT_W = 16;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]      FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  logic [1:0] reg_sel;
  logic       wr_en;
  logic       rd_en;
  logic       unused_addr_bits;

  assign reg_sel          = address[3:2];
  assign wr_en            = selected && write;
  assign rd_en            = selected && read;
  assign unused_addr_bits = ^{address[7:4], address[1:0]};

  uart_state_t      tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_idx;
  logic [7:0]       tx_shift;
  logic             tx_busy;
  logic             tx_load;
  logic             tx_bit_end;

  assign tx_busy    = (tx_state != S_IDLE);
  assign tx_load    = wr_en && (reg_sel == 2'd0) && !tx_busy;
  assign tx_bit_end = (tx_cnt == BIT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state  <= S_IDLE;
      tx_cnt    <= '0;
      tx_idx    <= '0;
      tx_signal <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (tx_load) begin
            tx_state  <= S_START;
            tx_cnt    <= '0;
            tx_signal <= 1'b0;
          end
        end
        S_START: begin
          if (tx_bit_end) begin
            tx_state  <= S_DATA;
            tx_cnt    <= '0;
            tx_idx    <= '0;
            tx_signal <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_idx == 3'd7) begin
              tx_state  <= S_STOP;
              tx_signal <= 1'b1;
            end else begin
              tx_idx    <= tx_idx + 3'd1;
              // bit 1 becomes bit 0 on this same edge
              tx_signal <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (tx_bit_end) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (tx_load)
      tx_shift <= in_data;
    else if (tx_state == S_DATA && tx_bit_end)
      tx_shift <= {1'b0, tx_shift[7:1]};
  end

  // Receive path: synchronizer, plus an arming flag so a line held low
  // through reset is not mistaken for a start bit.
  logic       rx_sync1;
  logic       rx_sync2;
  logic [1:0] rx_settle;
  logic       rx_armed;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_sync1  <= 1'b1;
      rx_sync2  <= 1'b1;
      rx_settle <= '0;
      rx_armed  <= 1'b0;
    end else begin
      rx_sync1  <= rx_signal;
      rx_sync2  <= rx_sync1;
      rx_settle <= {rx_settle[0], 1'b1};
      rx_armed  <= rx_armed | (rx_settle[1] & rx_sync2);
    end
  end

  uart_state_t      rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_idx;
  logic [7:0]       rx_shift;
  logic             rx_bit_end;
  logic             rx_half_end;
  logic             rx_stop_sample;
  logic             rx_push;
  logic             frame_err_set;

  assign rx_bit_end     = (rx_cnt == BIT_LAST);
  assign rx_half_end    = (rx_cnt == HALF_LAST);
  assign rx_stop_sample = (rx_state == S_STOP) && rx_bit_end;
  assign rx_push        = rx_stop_sample && rx_sync2;
  assign frame_err_set  = rx_stop_sample && !rx_sync2;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
    end else begin
      case (rx_state)
        S_IDLE: begin
          if (rx_armed && !rx_sync2) begin
            rx_state <= S_START;
            rx_cnt   <= '0;
          end
        end
        S_START: begin
          if (rx_half_end) begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_state <= rx_sync2 ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (rx_bit_end) begin
            rx_cnt <= '0;
            if (rx_idx == 3'd7)
              rx_state <= S_STOP;
            else
              rx_idx <= rx_idx + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (rx_bit_end) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (rx_state == S_DATA && rx_bit_end)
      rx_shift <= {rx_sync2, rx_shift[7:1]};
  end

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_count;
  logic          rx_empty;
  logic          rx_full;
  logic          fifo_pop;
  logic          fifo_push;
  logic          overrun_set;
  logic          status_clr;
  logic          rx_overrun;
  logic          rx_frame_err;

  assign rx_empty    = (fifo_count == '0);
  assign rx_full     = (fifo_count == FIFO_FULL);
  assign fifo_pop    = rd_en && (reg_sel == 2'd1) && !rx_empty;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign fifo_push   = rx_push && (!rx_full || fifo_pop);
  assign overrun_set = rx_push && rx_full && !fifo_pop;
  assign status_clr  = wr_en && (reg_sel == 2'd2);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (fifo_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (fifo_pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + (AW + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (overrun_set)
        rx_overrun <= 1'b1;
      else if (status_clr && in_data[3])
        rx_overrun <= 1'b0;
      if (frame_err_set)
        rx_frame_err <= 1'b1;
      else if (status_clr && in_data[4])
        rx_frame_err <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (fifo_push)
      fifo_mem[wr_ptr] <= rx_shift;
  end

  always_comb begin
    out_data = '0;
    case (reg_sel)
      2'd1:    if (!rx_empty) out_data = {24'b0, fifo_mem[rd_ptr]};
      2'd2:    out_data = {27'b0, rx_frame_err, rx_overrun, tx_busy, rx_full, rx_empty};
      default: out_data = '0;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_port.sv
// Randomized bench for mmio_uart_port against a queue-based model of the
// receive FIFO, sticky flags and the expected transmit waveform.
module tb_mmio_uart_port;

  localparam int C = 8;
  localparam int D = 4;

  logic        clock;
  logic        reset;
  logic        selected;
  logic        rx_signal;
  logic        tx_signal;
  logic [7:0]  address;
  logic [7:0]  in_data;
  logic        write;
  logic        read;
  logic [31:0] out_data;

  mmio_uart_port #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clock     (clock),
    .reset     (reset),
    .selected  (selected),
    .rx_signal (rx_signal),
    .tx_signal (tx_signal),
    .address   (address),
    .in_data   (in_data),
    .write     (write),
    .read      (read),
    .out_data  (out_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q[$];
  bit         m_overrun;
  bit         m_frame_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    return {27'b0, m_frame_err, m_overrun, 1'b0, q.size() == D, q.size() == 0};
  endfunction

  function automatic void model_reset();
    q.delete();
    m_overrun   = 1'b0;
    m_frame_err = 1'b0;
  endfunction

  // All bus tasks start and end 1 ns after a rising edge.
  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    selected = 1'b1; write = 1'b1; address = a; in_data = d;
    @(posedge clock); #1;
    selected = 1'b0; write = 1'b0;
  endtask

  task automatic rd_reg(input logic [7:0] a, output logic [31:0] v);
    selected = 1'b1; read = 1'b1; address = a;
    #1 v = out_data;
    @(posedge clock); #1;
    selected = 1'b0; read = 1'b0;
  endtask

  task automatic rdwr_reg(input logic [7:0] a, input logic [7:0] d, output logic [31:0] v);
    selected = 1'b1; read = 1'b1; write = 1'b1; address = a; in_data = d;
    #1 v = out_data;
    @(posedge clock); #1;
    selected = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  task automatic peek(input logic [7:0] a, output logic [31:0] v);
    selected = 1'b0; address = a;
    #1 v = out_data;
    @(posedge clock); #1;
  endtask

  task automatic check_status(input string tag);
    logic [31:0] v;
    peek(8'h08, v);
    check(tag, v, exp_status());
  endtask

  task automatic rx_read(input string tag);
    logic [31:0] v;
    logic [31:0] e;
    e = '0;
    rd_reg(8'h04, v);
    if (q.size() != 0) e = {24'b0, q.pop_front()};
    check(tag, v, e);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_signal = bits[i];
      repeat (C) @(posedge clock);
      #1;
    end
    rx_signal = 1'b1;
    repeat (2 * C) @(posedge clock);
    #1;
    if (!stop)            m_frame_err = 1'b1;
    else if (q.size() == D) m_overrun = 1'b1;
    else                  q.push_back(b);
  endtask

  task automatic tx_check(input logic [7:0] b, input logic [7:0] intruder, input bit try_drop);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    wr_reg(8'h00, b);
    for (int i = 0; i < 10 * C; i++) begin
      selected = 1'b0; write = 1'b0; address = 8'h08;
      #1;
      check("tx_line", {31'b0, tx_signal}, {31'b0, frame[i / C]});
      check("tx_busy", {31'b0, out_data[2]}, 32'd1);
      if (try_drop && i == 3) begin
        selected = 1'b1; write = 1'b1; address = 8'h00; in_data = intruder;
      end
      @(posedge clock); #1;
    end
    selected = 1'b0; write = 1'b0; address = 8'h08;
    #1;
    check("tx_busy_end", {31'b0, out_data[2]}, 32'd0);
    check("tx_idle_end", {31'b0, tx_signal}, 32'd1);
    @(posedge clock); #1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] e;
    logic [7:0]  b;
    bit          stop;

    reset = 1'b0; selected = 1'b0; write = 1'b0; read = 1'b0;
    address = '0; in_data = '0; rx_signal = 1'b1;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("reset_tx", {31'b0, tx_signal}, 32'd1);
    peek(8'h08, v);
    check("reset_status", v, 32'h1);
    reset = 1'b1;
    repeat (4) @(posedge clock);
    #1;

    // Transmit: fixed pattern with a dropped write, then random bytes.
    tx_check(8'hA5, 8'h5A, 1'b1);
    for (int k = 0; k < 2; k++) begin
      b = 8'($urandom);
      tx_check(b, ~b, 1'b1);
    end

    // Reset in the middle of a data bit aborts the frame.
    wr_reg(8'h00, 8'h00);
    repeat (4 * C) @(posedge clock);
    #1;
    check("tx_mid_data", {31'b0, tx_signal}, 32'd0);
    reset = 1'b0;
    #1;
    check("tx_async_reset", {31'b0, tx_signal}, 32'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_status("status_after_reset");
    tx_check(8'($urandom), 8'hFF, 1'b0);

    // Single receive frame.
    send_frame(8'h3C, 1'b1);
    check_status("rx_one_status");
    rx_read("rx_one_data");
    check_status("rx_one_drained");

    // Short low pulse is rejected.
    rx_signal = 1'b0;
    repeat (C / 4) @(posedge clock);
    #1;
    rx_signal = 1'b1;
    repeat (3 * C) @(posedge clock);
    #1;
    check_status("glitch_status");

    // Framing error and its clear.
    send_frame(8'h55, 1'b0);
    check_status("frame_err_status");
    wr_reg(8'h08, 8'h10);
    m_frame_err = 1'b0;
    check_status("frame_err_clear");

    // Overflow the FIFO.
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1);
    check_status("overrun_status");
    for (int k = 0; k < 4; k++) rx_read("overrun_data");
    rx_read("read_empty");
    check_status("empty_read_status");
    wr_reg(8'h08, 8'h08);
    m_overrun = 1'b0;
    check_status("overrun_clear");

    // Unmapped and write-only registers read as zero, writes ignored.
    peek(8'h0C, v);
    check("reg_0c_read", v, 32'h0);
    wr_reg(8'h0C, 8'hFF);
    rd_reg(8'h00, v);
    check("reg_00_read", v, 32'h0);
    check_status("after_0c_write");

    // Random frames, reads and combined read+write status clears.
    for (int k = 0; k < 12; k++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      send_frame(b, stop);
      if ($urandom_range(0, 1) == 1) rx_read("rand_data");
      if ($urandom_range(0, 2) == 0) begin
        e = exp_status();
        rdwr_reg(8'h08, 8'h18, v);
        check("rand_rdwr_status", v, e);
        m_overrun   = 1'b0;
        m_frame_err = 1'b0;
      end
      check_status("rand_status");
    end
    while (q.size() != 0) rx_read("drain_data");
    rx_read("drain_empty");
    check_status("drain_status");

    // Line held low through reset must not start a frame.
    reset = 1'b0;
    rx_signal = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
    repeat (2 * C) @(posedge clock);
    #1;
    rx_signal = 1'b1;
    repeat (12 * C) @(posedge clock);
    #1;
    check_status("low_through_reset");
    send_frame(8'($urandom), 1'b1);
    check_status("post_reset_frame_status");
    rx_read("post_reset_frame_data");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
